// File: rtl/rice_bus_memory_slave.sv
// Word-addressed memory slave for one rice bus port, with an in-order response FIFO.
// Optional master-backpressure stall: define RICE_BUS_MEMORY_SLAVE_RANDOM_STALL_EN.
module rice_bus_memory_slave #(
  parameter int                       ADDRESS_WIDTH  = 64,
  parameter int                       DATA_WIDTH     = 64,
  parameter int                       WORD_COUNT     = 4096,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS   = '0,
  parameter int                       RESPONSE_DEPTH = 2,
  parameter logic [15:0]              STALL_SEED     = 16'hACE1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_request_valid,
  output logic                      o_request_ready,
  input  logic [ADDRESS_WIDTH-1:0]  i_address,
  input  logic [DATA_WIDTH/8-1:0]   i_strobe,
  input  logic [DATA_WIDTH-1:0]     i_write_data,
  output logic                      o_response_valid,
  input  logic                      i_response_ready,
  output logic [DATA_WIDTH-1:0]     o_read_data,
  output logic                      o_error
);

  localparam int STROBE_WIDTH = DATA_WIDTH / 8;
  localparam int OFFSET_BITS  = $clog2(STROBE_WIDTH);
  localparam int INDEX_BITS   = $clog2(WORD_COUNT);
  localparam int PTR_BITS     = $clog2(RESPONSE_DEPTH);
  localparam int COUNT_BITS   = PTR_BITS + 1;
  localparam logic [ADDRESS_WIDTH:0] SPAN  = (ADDRESS_WIDTH+1)'(WORD_COUNT * STROBE_WIDTH);
  localparam logic [ADDRESS_WIDTH:0] LIMIT = {1'b0, BASE_ADDRESS} + SPAN;

  logic [DATA_WIDTH-1:0] mem_q [WORD_COUNT];
  logic [DATA_WIDTH-1:0] resp_data_q [RESPONSE_DEPTH];
  logic                  resp_error_q [RESPONSE_DEPTH];

  logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic                  ready_q, ready_d;

  logic                     accept, pop, is_write, addr_error, write_en, stall;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic [INDEX_BITS-1:0]    word_index;
  logic [DATA_WIDTH-1:0]    stored_word, merged_word, entry_data;

`ifdef RICE_BUS_MEMORY_SLAVE_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // lfsr_d is the value held during the cycle the next registered ready applies to
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    stall  = (lfsr_d[1:0] == 2'b00);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) lfsr_q <= STALL_SEED;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    accept     = i_request_valid && ready_q;
    pop        = (count_q != '0) && i_response_ready;
    is_write   = |i_strobe;
    offset     = i_address - BASE_ADDRESS;
    word_index = offset[OFFSET_BITS +: INDEX_BITS];
    addr_error = ({1'b0, i_address} < {1'b0, BASE_ADDRESS}) ||
                 ({1'b0, i_address} >= LIMIT) ||
                 (i_address[OFFSET_BITS-1:0] != '0);
    stored_word = mem_q[word_index];
    merged_word = stored_word;
    for (int i = 0; i < STROBE_WIDTH; i++) begin
      if (i_strobe[i]) merged_word[8*i +: 8] = i_write_data[8*i +: 8];
    end
    entry_data = (addr_error || is_write) ? '0 : stored_word;
    write_en   = accept && is_write && !addr_error;
  end

  always_comb begin
    wr_ptr_d = accept ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;
    count_d  = count_q;
    if (accept && !pop)      count_d = count_q + COUNT_BITS'(1);
    else if (!accept && pop) count_d = count_q - COUNT_BITS'(1);
    ready_d  = (count_d < COUNT_BITS'(RESPONSE_DEPTH)) && !stall;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Storage is never reset; stale entries are hidden by gating outputs with valid
  always_ff @(posedge i_clk) begin
    if (write_en) mem_q[word_index] <= merged_word;
    if (accept) begin
      resp_data_q[wr_ptr_q]  <= entry_data;
      resp_error_q[wr_ptr_q] <= addr_error;
    end
  end

  assign o_request_ready  = ready_q;
  assign o_response_valid = (count_q != '0);
  assign o_read_data      = o_response_valid ? resp_data_q[rd_ptr_q] : '0;
  assign o_error          = o_response_valid ? resp_error_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_rice_bus_memory_slave.sv
// Bench for rice_bus_memory_slave: directed vector table, backpressure/reset sequences,
// then randomized traffic against a queue-based reference model.
module tb_rice_bus_memory_slave;

  logic        i_clk;
  logic        i_rst;
  logic        i_request_valid;
  logic        o_request_ready;
  logic [63:0] i_address;
  logic [7:0]  i_strobe;
  logic [63:0] i_write_data;
  logic        o_response_valid;
  logic        i_response_ready;
  logic [63:0] o_read_data;
  logic        o_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic        exp_valid;
    logic [63:0] exp_data;
    logic        exp_err;
    logic        exp_ready;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } resp_t;

  vec_t        vecs [13];
  resp_t       exp_q [$];
  logic [63:0] ref_mem [4096];
  logic        model_ready;

  rice_bus_memory_slave dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_request_valid  (i_request_valid),
    .o_request_ready  (o_request_ready),
    .i_address        (i_address),
    .i_strobe         (i_strobe),
    .i_write_data     (i_write_data),
    .o_response_valid (o_response_valid),
    .i_response_ready (i_response_ready),
    .o_read_data      (o_read_data),
    .o_error          (o_error)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [63:0] a, input logic [7:0] s,
                                input logic [63:0] d, input logic rr);
    i_request_valid  = v;
    i_address        = a;
    i_strobe         = s;
    i_write_data     = d;
    i_response_ready = rr;
  endtask

  task automatic set_vec(input int k, input logic v, input logic [63:0] a, input logic [7:0] s,
                         input logic [63:0] d, input logic ev, input logic [63:0] ed,
                         input logic ee, input logic er);
    vecs[k] = '{v, a, s, d, ev, ed, ee, er};
  endtask

  // Model: an error is any address outside the 4096-word window or not word aligned
  function automatic logic addr_bad(input logic [63:0] a);
    return (a >= 64'd32768) || (a % 8 != 0);
  endfunction

  task automatic model_step(input logic v, input logic [63:0] a, input logic [7:0] s,
                            input logic [63:0] d, input logic rr, output logic accepted);
    logic  do_pop;
    resp_t r;
    apply_stimulus(v, a, s, d, rr);
    check_output("rand_ready", 64'(o_request_ready), 64'(model_ready));
    check_output("rand_valid", 64'(o_response_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_output("rand_data", o_read_data, exp_q[0].data);
      check_output("rand_err", 64'(o_error), 64'(exp_q[0].err));
    end
    accepted = v && model_ready;
    do_pop   = (exp_q.size() != 0) && rr;
    @(posedge i_clk);
    if (do_pop) void'(exp_q.pop_front());
    if (accepted) begin
      r.err  = addr_bad(a);
      r.data = 64'h0;
      if (!r.err && s == 8'h00) r.data = ref_mem[a / 8];
      if (!r.err && s != 8'h00) begin
        for (int b = 0; b < 8; b++)
          if (s[b]) ref_mem[a / 8][8*b +: 8] = d[8*b +: 8];
      end
      exp_q.push_back(r);
    end
    model_ready = exp_q.size() < 2;
    #1;
  endtask

  initial begin
    logic        acc;
    logic [63:0] a;
    logic [7:0]  s;
    int          tries;

    apply_stimulus(1'b0, 64'h0, 8'h0, 64'h0, 1'b1);
    i_rst = 1'b1;

    // Reset held for three cycles
    for (int c = 0; c < 3; c++) begin
      step();
      check_output("rst_ready", 64'(o_request_ready), 64'h0);
      check_output("rst_valid", 64'(o_response_valid), 64'h0);
      check_output("rst_data", o_read_data, 64'h0);
      check_output("rst_err", 64'(o_error), 64'h0);
    end
    i_rst = 1'b0;
    #1;
    check_output("rel_ready_low", 64'(o_request_ready), 64'h0);
    step();
    check_output("rel_ready_high", 64'(o_request_ready), 64'h1);

    // Each row: inputs for this cycle, outputs expected before the edge
    set_vec(0,  1, 64'h10,   8'hFF, 64'h1122334455667788, 0, 64'h0, 0, 1);
    set_vec(1,  1, 64'h10,   8'h00, 64'h0,                1, 64'h0, 0, 1);
    set_vec(2,  1, 64'h10,   8'h01, 64'hAAAAAAAAAAAAAAAA, 1, 64'h1122334455667788, 0, 1);
    set_vec(3,  1, 64'h10,   8'h00, 64'h0,                1, 64'h0, 0, 1);
    set_vec(4,  1, 64'h13,   8'h00, 64'h0,                1, 64'h11223344556677AA, 0, 1);
    set_vec(5,  1, 64'h8000, 8'h00, 64'h0,                1, 64'h0, 1, 1);
    set_vec(6,  1, 64'h14,   8'hFF, 64'h0,                1, 64'h0, 1, 1);
    set_vec(7,  1, 64'h10,   8'h00, 64'h0,                1, 64'h0, 1, 1);
    set_vec(8,  1, 64'h7FF8, 8'hFF, 64'h0123456789ABCDEF, 1, 64'h11223344556677AA, 0, 1);
    set_vec(9,  1, 64'h7FF8, 8'h00, 64'h0,                1, 64'h0, 0, 1);
    set_vec(10, 1, 64'h8000, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1, 64'h0123456789ABCDEF, 0, 1);
    set_vec(11, 0, 64'h0,    8'h00, 64'h0,                1, 64'h0, 1, 1);
    set_vec(12, 0, 64'h0,    8'h00, 64'h0,                0, 64'h0, 0, 1);

    for (int k = 0; k < 13; k++) begin
      apply_stimulus(vecs[k].valid, vecs[k].addr, vecs[k].strb, vecs[k].wdata, 1'b1);
      check_output($sformatf("vec%0d_valid", k), 64'(o_response_valid), 64'(vecs[k].exp_valid));
      check_output($sformatf("vec%0d_data", k), o_read_data, vecs[k].exp_data);
      check_output($sformatf("vec%0d_err", k), 64'(o_error), 64'(vecs[k].exp_err));
      check_output($sformatf("vec%0d_ready", k), 64'(o_request_ready), 64'(vecs[k].exp_ready));
      step();
    end

    // Backpressure: three reads with responses held off
    apply_stimulus(1, 64'h10, 8'h0, 64'h0, 1'b0);
    check_output("bp_ready0", 64'(o_request_ready), 64'h1);
    step();
    apply_stimulus(1, 64'h7FF8, 8'h0, 64'h0, 1'b0);
    check_output("bp_ready1", 64'(o_request_ready), 64'h1);
    check_output("bp_head1", o_read_data, 64'h11223344556677AA);
    step();
    apply_stimulus(1, 64'h8000, 8'h0, 64'h0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      check_output("bp_full_ready", 64'(o_request_ready), 64'h0);
      check_output("bp_full_head", o_read_data, 64'h11223344556677AA);
      step();
    end
    i_response_ready = 1'b1;
    check_output("bp_pop_ready", 64'(o_request_ready), 64'h0);
    step();
    check_output("bp_after_pop_ready", 64'(o_request_ready), 64'h1);
    check_output("bp_second_data", o_read_data, 64'h0123456789ABCDEF);
    check_output("bp_second_err", 64'(o_error), 64'h0);
    step();
    i_request_valid = 1'b0;
    check_output("bp_third_valid", 64'(o_response_valid), 64'h1);
    check_output("bp_third_err", 64'(o_error), 64'h1);
    check_output("bp_third_data", o_read_data, 64'h0);
    step();
    check_output("bp_drained", 64'(o_response_valid), 64'h0);

    // Reset with two responses pending
    apply_stimulus(1, 64'h10, 8'h0, 64'h0, 1'b0);
    step();
    step();
    i_request_valid = 1'b0;
    check_output("mid_pending", 64'(o_response_valid), 64'h1);
    i_rst = 1'b1;
    #1;
    check_output("mid_rst_valid", 64'(o_response_valid), 64'h0);
    check_output("mid_rst_ready", 64'(o_request_ready), 64'h0);
    step();
    step();
    i_rst = 1'b0;
    i_response_ready = 1'b1;
    step();
    check_output("mid_rel_ready", 64'(o_request_ready), 64'h1);
    check_output("mid_no_stale", 64'(o_response_valid), 64'h0);

    // Randomized traffic against the model, starting from a fresh reset
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    exp_q.delete();
    model_ready = 1'b0;
    model_step(1'b0, 64'h0, 8'h0, 64'h0, 1'b1, acc);
    for (int w = 0; w < 16; w++) begin
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
        model_step(1'b1, 64'(w * 8), 8'hFF, {$urandom, $urandom}, ($urandom_range(0, 3) != 0), acc);
        tries++;
      end
      if (!acc) check_output("init_accept_timeout", 64'h0, 64'h1);
    end
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 64'h8000 + 64'($urandom_range(0, 255) * 8);
        1:       a = 64'($urandom_range(0, 15) * 8 + $urandom_range(1, 7));
        default: a = 64'($urandom_range(0, 15) * 8);
      endcase
      s = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(1, 255));
      model_step(($urandom_range(0, 9) < 7), a, s, {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0), acc);
    end
    tries = 0;
    while (exp_q.size() != 0 && tries < 10) begin
      model_step(1'b0, 64'h0, 8'h0, 64'h0, 1'b1, acc);
      tries++;
    end
    if (exp_q.size() != 0) check_output("drain_timeout", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
